dht11_request_sequencer: RTL and testbench
==========================================

# dht11_request_sequencer

Command-driven sequencer directly downstream of the DHT11 single-wire communication block and upstream of the UART transmitter. It accepts one request byte at a time, restarts and enables the DHT11 block, waits for its completion flag or a timeout, and emits a two-byte response (code, value) over a valid/ready byte stream. It supports one-shot and periodic (continuous) humidity or temperature reads.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100_000_000: MEASURE cycles allowed before declaring sensor failure (2 s @ 50 MHz)
- PERIOD_CYCLES, 100_000_000: CONT_WAIT cycles between continuous reads
- SETTLE_CYCLES, 2: initial MEASURE cycles during which sensor_done is ignored

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  request byte present
- cmd_code  in  8  request code
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
- sensor_enable  out  8  DHT11 block enable; 8'h01 = run, 8'h00 = frozen
- sensor_reset  out  1  active-high restart pulse to DHT11 block
- sensor_done  in  1  DHT11 data-valid flag
- hum_int  in  8  humidity integer byte
- temp_int  in  8  temperature integer byte
- tx_valid  out  1  response byte valid
- tx_data  out  8  response byte
- tx_ready  in  1  transmitter accepts byte

## Operation
- Request codes: 0x00 status, 0x01 humidity, 0x02 temperature, 0x03 continuous humidity, 0x04 continuous temperature, 0x05 stop continuous humidity, 0x06 stop continuous temperature.
- Response codes: 0x07 sensor OK, 0x08 humidity, 0x09 temperature, 0x0A continuous humidity off, 0x0B continuous temperature off, 0x1F sensor error, 0xEF invalid request.
- Value byte: hum_int/temp_int captured at success; 0x00 for status, error, invalid and stop acks.
- States: IDLE, RST_SENSOR, MEASURE, SEND_CODE, SEND_VALUE, CONT_WAIT.
- IDLE: cmd_ready=1. Codes 0x00–0x04 -> RST_SENSOR; 0x03/0x04 also set cont_mode (hum/temp). Any other code, including 0x05/0x06 -> SEND_CODE with 0xEF.
- RST_SENSOR: one cycle, sensor_enable=8'h01, sensor_reset=1 -> MEASURE.
- MEASURE: sensor_enable=8'h01, sensor_reset=0, timeout counter counts. After SETTLE_CYCLES, sensor_done=1 -> latch hum_int and temp_int, result OK. Counter reaching TIMEOUT_CYCLES-1 without done -> result error (0x1F), cont_mode cleared. Done and timeout in the same cycle: done wins.
- SEND_CODE -> SEND_VALUE -> IDLE, or CONT_WAIT if cont_mode is still set.
- CONT_WAIT: cmd_ready=1, sensor_enable=8'h00, period counter counts. Matching stop (0x05 for hum, 0x06 for temp) -> clear cont_mode, send 0x0A/0x0B with 0x00, then IDLE. Any other accepted code -> send 0xEF and return to CONT_WAIT with the period counter preserved. Period expiry -> RST_SENSOR. Command acceptance and period expiry in the same cycle: command wins.
- sensor_enable is 8'h00 outside RST_SENSOR/MEASURE.

## Timing
- Reset values: cmd_ready=0, sensor_enable=8'h00, sensor_reset=0, tx_valid=0, tx_data=8'h00; state IDLE; counters 0; cont_mode clear. cmd_ready rises the first cycle after reset release.
- Command accepted at edge N: sensor_reset=1 during cycle N+1, MEASURE from N+2.
- Invalid command accepted at N: tx_valid=1 from N+1.
- Done seen at edge M: tx_valid=1 with the code byte from M+1.
- tx_valid/tx_data are registered and held stable until tx_ready. The value byte is presented the cycle after the code byte is accepted. No combinational path from tx_ready to tx_valid.
- Reset mid-operation: immediate return to reset values. The sensor block is left frozen (enable 8'h00).

## Structure
- Package dht11_pkg: request/response code constants, state enum, response value for non-data codes (8'h00).
- Optional sub-module dht11_cycle_timer: load/count/expire counter shared by the MEASURE timeout and the CONT_WAIT period (one instance, reloaded per state).

## Test plan
- Status request 0x00, sensor model raises done 5 cycles into MEASURE -> bytes 0x07, 0x00; sensor_reset pulsed exactly once.
- Humidity 0x01 with hum_int=0x37, tx_ready low 3 cycles -> 0x08 held stable, then 0x37; then IDLE.
- Temperature 0x02, done never rises, TIMEOUT_CYCLES=50 -> 0x1F, 0x00 after exactly 50 MEASURE cycles; sensor_enable drops to 0x00.
- Continuous temp 0x04, PERIOD_CYCLES=20, temp_int 0x19 then 0x1A -> 0x09,0x19 then 0x09,0x1A; then 0x06 -> 0x0B,0x00 and no further measurements.
- 0x05 during continuous temp, and 0xAA in IDLE -> 0xEF,0x00 each time; continuous reads continue.
- Reset asserted during MEASURE and during SEND_VALUE -> all outputs at reset values asynchronously; next request is serviced normally.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared codes, state encoding and response helpers for the DHT11 request sequencer.
package dht11_pkg;

  localparam int CNT_W = 32;

  localparam logic [7:0] REQ_STATUS    = 8'h00;
  localparam logic [7:0] REQ_HUM       = 8'h01;
  localparam logic [7:0] REQ_TEMP      = 8'h02;
  localparam logic [7:0] REQ_CONT_HUM  = 8'h03;
  localparam logic [7:0] REQ_CONT_TEMP = 8'h04;
  localparam logic [7:0] REQ_STOP_HUM  = 8'h05;
  localparam logic [7:0] REQ_STOP_TEMP = 8'h06;

  localparam logic [7:0] RSP_OK       = 8'h07;
  localparam logic [7:0] RSP_HUM      = 8'h08;
  localparam logic [7:0] RSP_TEMP     = 8'h09;
  localparam logic [7:0] RSP_HUM_OFF  = 8'h0A;
  localparam logic [7:0] RSP_TEMP_OFF = 8'h0B;
  localparam logic [7:0] RSP_ERR      = 8'h1F;
  localparam logic [7:0] RSP_INVALID  = 8'hEF;
  localparam logic [7:0] RSP_NODATA   = 8'h00;

  localparam logic [7:0] SENSOR_RUN    = 8'h01;
  localparam logic [7:0] SENSOR_FREEZE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_SENSOR,
    ST_MEASURE,
    ST_SEND_CODE,
    ST_SEND_VALUE,
    ST_CONT_WAIT
  } state_e;

  typedef enum logic [1:0] {
    KIND_STATUS,
    KIND_HUM,
    KIND_TEMP
  } kind_e;

  function automatic logic [7:0] ok_code(input kind_e k);
    case (k)
      KIND_HUM:  return RSP_HUM;
      KIND_TEMP: return RSP_TEMP;
      default:   return RSP_OK;
    endcase
  endfunction

endpackage

// File: rtl/dht11_cycle_timer.sv
// Free-running cycle counter with synchronous clear and a programmable terminal value.
module dht11_cycle_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] count_o,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o  = cnt_q;
  assign expire_o = (cnt_q == last_i);

endmodule

// File: rtl/dht11_request_sequencer.sv
// Turns single request bytes into DHT11 measurements and (code, value) response pairs,
// including periodic reads; all outputs are registered decodes of the next state.
module dht11_request_sequencer
  import dht11_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  output logic       cmd_ready,
  output logic [7:0] sensor_enable,
  output logic       sensor_reset,
  input  logic       sensor_done,
  input  logic [7:0] hum_int,
  input  logic [7:0] temp_int,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic       cont_q, cont_d, cont_temp_q, cont_temp_d;
  logic [7:0] code_q, code_d, val_q, val_d;

  logic       cmd_ready_q, sensor_reset_q, tx_valid_q;
  logic [7:0] sensor_enable_q, tx_data_q;

  logic             tmr_clr, tmr_en, tmr_expire;
  logic [CNT_W-1:0] tmr_last, tmr_cnt;
  logic             cmd_fire, stop_match;

  assign cmd_fire   = cmd_valid & cmd_ready_q;
  assign stop_match = cont_temp_q ? (cmd_code == REQ_STOP_TEMP) : (cmd_code == REQ_STOP_HUM);

  // One timer serves both the measurement timeout and the continuous-read period.
  dht11_cycle_timer #(.W(CNT_W)) u_timer (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .last_i   (tmr_last),
    .count_o  (tmr_cnt),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cont_d      = cont_q;
    cont_temp_d = cont_temp_q;
    code_d      = code_q;
    val_d       = val_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    tmr_last    = TMO_LAST;
    unique case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (cmd_fire) begin
          state_d = ST_RST_SENSOR;
          case (cmd_code)
            REQ_STATUS: kind_d = KIND_STATUS;
            REQ_HUM:    kind_d = KIND_HUM;
            REQ_TEMP:   kind_d = KIND_TEMP;
            REQ_CONT_HUM: begin
              kind_d      = KIND_HUM;
              cont_d      = 1'b1;
              cont_temp_d = 1'b0;
            end
            REQ_CONT_TEMP: begin
              kind_d      = KIND_TEMP;
              cont_d      = 1'b1;
              cont_temp_d = 1'b1;
            end
            default: begin
              state_d = ST_SEND_CODE;
              code_d  = RSP_INVALID;
              val_d   = RSP_NODATA;
            end
          endcase
        end
      end
      ST_RST_SENSOR: begin
        tmr_clr = 1'b1;
        state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        tmr_en = 1'b1;
        // Done beats timeout; leaving clears the timer so CONT_WAIT starts a fresh period.
        if (sensor_done && (tmr_cnt >= SETTLE)) begin
          tmr_clr = 1'b1;
          state_d = ST_SEND_CODE;
          code_d  = ok_code(kind_q);
          case (kind_q)
            KIND_HUM:  val_d = hum_int;
            KIND_TEMP: val_d = temp_int;
            default:   val_d = RSP_NODATA;
          endcase
        end else if (tmr_expire) begin
          tmr_clr = 1'b1;
          state_d = ST_SEND_CODE;
          code_d  = RSP_ERR;
          val_d   = RSP_NODATA;
          cont_d  = 1'b0;
        end
      end
      ST_SEND_CODE: begin
        if (tx_ready) state_d = ST_SEND_VALUE;
      end
      ST_SEND_VALUE: begin
        if (tx_ready) state_d = cont_q ? ST_CONT_WAIT : ST_IDLE;
      end
      ST_CONT_WAIT: begin
        tmr_last = PER_LAST;
        // A command freezes the period count so an invalid request does not shift the schedule.
        if (cmd_fire) begin
          state_d = ST_SEND_CODE;
          val_d   = RSP_NODATA;
          if (stop_match) begin
            cont_d = 1'b0;
            code_d = cont_temp_q ? RSP_TEMP_OFF : RSP_HUM_OFF;
          end else begin
            code_d = RSP_INVALID;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) state_d = ST_RST_SENSOR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      kind_q          <= KIND_STATUS;
      cont_q          <= 1'b0;
      cont_temp_q     <= 1'b0;
      code_q          <= RSP_NODATA;
      val_q           <= RSP_NODATA;
      cmd_ready_q     <= 1'b0;
      sensor_enable_q <= SENSOR_FREEZE;
      sensor_reset_q  <= 1'b0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= RSP_NODATA;
    end else begin
      state_q         <= state_d;
      kind_q          <= kind_d;
      cont_q          <= cont_d;
      cont_temp_q     <= cont_temp_d;
      code_q          <= code_d;
      val_q           <= val_d;
      cmd_ready_q     <= (state_d == ST_IDLE) || (state_d == ST_CONT_WAIT);
      sensor_enable_q <= ((state_d == ST_RST_SENSOR) || (state_d == ST_MEASURE)) ?
                         SENSOR_RUN : SENSOR_FREEZE;
      sensor_reset_q  <= (state_d == ST_RST_SENSOR);
      tx_valid_q      <= (state_d == ST_SEND_CODE) || (state_d == ST_SEND_VALUE);
      tx_data_q       <= (state_d == ST_SEND_CODE)  ? code_d :
                         (state_d == ST_SEND_VALUE) ? val_d  : RSP_NODATA;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign sensor_enable = sensor_enable_q;
  assign sensor_reset  = sensor_reset_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;

endmodule

// File: tb/tb_dht11_request_sequencer.sv
// Randomized scenario bench for dht11_request_sequencer with a request/response reference model.
module tb_dht11_request_sequencer;

  localparam int TMO = 50;
  localparam int PER = 20;
  localparam int SET = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code = 8'h00;
  logic       cmd_ready;
  logic [7:0] sensor_enable;
  logic       sensor_reset;
  logic       sensor_done = 1'b0;
  logic [7:0] hum_int = 8'h00;
  logic [7:0] temp_int = 8'h00;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;

  int done_delay = -1;
  int mc = 0;
  int rst_pulses = 0;
  int meas_cycles = 0;
  int n_cmp = 0;
  int n_err = 0;

  dht11_request_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_CYCLES  (PER),
    .SETTLE_CYCLES  (SET)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_ready     (cmd_ready),
    .sensor_enable (sensor_enable),
    .sensor_reset  (sensor_reset),
    .sensor_done   (sensor_done),
    .hum_int       (hum_int),
    .temp_int      (temp_int),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready)
  );

  always #5 clock = ~clock;

  // Sensor model: done rises done_delay enabled cycles after the restart pulse and stays up.
  always @(negedge clock) begin
    if (sensor_reset) begin
      mc = 0;
      rst_pulses++;
    end else if (sensor_enable == 8'h01) begin
      mc++;
      meas_cycles++;
    end
    sensor_done = (done_delay >= 0) && (sensor_enable == 8'h01) && !sensor_reset && (mc >= done_delay);
  end

  // Reference: response pair from request, continuous context and sensor outcome.
  function automatic logic [15:0] model_rsp(input logic [7:0] req, input bit in_cont,
                                            input bit cont_temp, input bit ok,
                                            input logic [7:0] h, input logic [7:0] t);
    if (in_cont)
      return (req == (cont_temp ? 8'h06 : 8'h05)) ? {(cont_temp ? 8'h0B : 8'h0A), 8'h00} : 16'hEF00;
    if (req > 8'h04) return 16'hEF00;
    if (!ok) return 16'h1F00;
    if (req == 8'h00) return 16'h0700;
    if (req == 8'h01 || req == 8'h03) return {8'h08, h};
    return {8'h09, t};
  endfunction

  function automatic int model_meas(input int d);
    if (d < 0 || d > TMO) return TMO;
    return (d > SET) ? d : SET + 1;
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    int w = 0;
    while (!cmd_ready && w < 400) begin @(negedge clock); w++; end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
      return;
    end
    cmd_valid = 1'b1;
    cmd_code  = c;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic get_byte(input string nm, input int stall, output logic [7:0] b);
    int w = 0;
    b = 8'h00;
    while (!tx_valid && w < 400) begin @(negedge clock); w++; end
    if (!tx_valid) begin
      n_cmp++; n_err++;
      $display("FAIL %s_wait: tx_valid=%b after %0d cycles, required 1", nm, tx_valid, w);
      return;
    end
    b = tx_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin
        n_err++;
        $display("FAIL %s_hold: valid=%b data=%h, required valid=1 data=%h", nm, tx_valid, tx_data, b);
      end
    end
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
  endtask

  task automatic rx_pair(input string nm, input int s0, input int s1, output logic [15:0] p);
    logic [7:0] c, v;
    get_byte(nm, s0, c);
    get_byte(nm, s1, v);
    p = {c, v};
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({cmd_ready, sensor_enable, sensor_reset, tx_valid, tx_data} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b en=%h srst=%b txv=%b txd=%h, required all 0",
               cmd_ready, sensor_enable, sensor_reset, tx_valid, tx_data);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
    end
    @(negedge clock);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_release: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_status;
    logic [15:0] p;
    int r0, m0;
    done_delay = 5;
    r0 = rst_pulses; m0 = meas_cycles;
    send_cmd(8'h00);
    n_cmp++;
    if (sensor_reset !== 1'b1 || sensor_enable !== 8'h01) begin
      n_err++; $display("FAIL status_rst_cycle: srst=%b en=%h required 1/01", sensor_reset, sensor_enable);
    end
    @(negedge clock);
    n_cmp++;
    if (sensor_reset !== 1'b0 || sensor_enable !== 8'h01) begin
      n_err++; $display("FAIL status_measure: srst=%b en=%h required 0/01", sensor_reset, sensor_enable);
    end
    rx_pair("status", 0, 0, p);
    n_cmp++;
    if (p !== model_rsp(8'h00, 0, 0, 1, hum_int, temp_int)) begin
      n_err++; $display("FAIL status_rsp: got %h required %h", p, model_rsp(8'h00, 0, 0, 1, hum_int, temp_int));
    end
    n_cmp++;
    if (rst_pulses - r0 !== 1 || meas_cycles - m0 !== model_meas(5)) begin
      n_err++; $display("FAIL status_pulses: pulses=%0d meas=%0d required 1/%0d",
                        rst_pulses - r0, meas_cycles - m0, model_meas(5));
    end
  endtask

  task automatic test_humidity;
    logic [15:0] p;
    for (int k = 0; k < 3; k++) begin
      hum_int    = (k == 0) ? 8'h37 : 8'($urandom_range(0, 255));
      temp_int   = 8'($urandom_range(0, 255));
      done_delay = $urandom_range(1, 10);
      send_cmd(8'h01);
      rx_pair("humidity", 3, $urandom_range(0, 2), p);
      n_cmp++;
      if (p !== model_rsp(8'h01, 0, 0, 1, hum_int, temp_int)) begin
        n_err++; $display("FAIL humidity_rsp: got %h required %h", p, model_rsp(8'h01, 0, 0, 1, hum_int, temp_int));
      end
      n_cmp++;
      if (cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
        n_err++; $display("FAIL humidity_idle: rdy=%b txv=%b required 1/0", cmd_ready, tx_valid);
      end
    end
  endtask

  task automatic test_timeout;
    logic [15:0] p;
    int m0;
    done_delay = -1;
    m0 = meas_cycles;
    send_cmd(8'h02);
    rx_pair("timeout", 0, 0, p);
    n_cmp++;
    if (p !== model_rsp(8'h02, 0, 0, 0, hum_int, temp_int)) begin
      n_err++; $display("FAIL timeout_rsp: got %h required %h", p, model_rsp(8'h02, 0, 0, 0, hum_int, temp_int));
    end
    n_cmp++;
    if (meas_cycles - m0 !== TMO) begin
      n_err++; $display("FAIL timeout_cycles: got %0d required %0d", meas_cycles - m0, TMO);
    end
    n_cmp++;
    if (sensor_enable !== 8'h00) begin
      n_err++; $display("FAIL timeout_enable: got %h required 00", sensor_enable);
    end
  endtask

  task automatic test_continuous;
    logic [15:0] p;
    int w, r0;
    done_delay = $urandom_range(3, 8);
    temp_int = 8'h19;
    send_cmd(8'h04);
    rx_pair("cont1", 0, 0, p);
    n_cmp++;
    if (p !== model_rsp(8'h04, 0, 1, 1, hum_int, 8'h19)) begin
      n_err++; $display("FAIL cont1_rsp: got %h required %h", p, model_rsp(8'h04, 0, 1, 1, hum_int, 8'h19));
    end
    temp_int = 8'h1A;
    w = 0;
    while (!sensor_reset && w < 200) begin @(negedge clock); w++; end
    n_cmp++;
    if (w !== PER) begin
      n_err++; $display("FAIL cont_period: got %0d cycles required %0d", w, PER);
    end
    rx_pair("cont2", 0, 1, p);
    n_cmp++;
    if (p !== model_rsp(8'h04, 0, 1, 1, hum_int, 8'h1A)) begin
      n_err++; $display("FAIL cont2_rsp: got %h required %h", p, model_rsp(8'h04, 0, 1, 1, hum_int, 8'h1A));
    end
    send_cmd(8'h06);
    rx_pair("cont_stop", 0, 0, p);
    n_cmp++;
    if (p !== model_rsp(8'h06, 1, 1, 1, hum_int, temp_int)) begin
      n_err++; $display("FAIL cont_stop_rsp: got %h required %h", p, model_rsp(8'h06, 1, 1, 1, hum_int, temp_int));
    end
    r0 = rst_pulses;
    repeat (3 * PER) @(negedge clock);
    n_cmp++;
    if (rst_pulses - r0 !== 0 || cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_err++; $display("FAIL cont_stopped: pulses=%0d rdy=%b txv=%b required 0/1/0",
                        rst_pulses - r0, cmd_ready, tx_valid);
    end
  endtask

  task automatic test_invalid;
    logic [15:0] p, e;
    logic [7:0] rc, h2;
    done_delay = $urandom_range(2, 6);
    hum_int = 8'($urandom_range(0, 255));
    send_cmd(8'h03);
    rx_pair("inv_cont1", 0, 0, p);
    e = model_rsp(8'h03, 0, 0, 1, hum_int, temp_int);
    n_cmp++;
    if (p !== e) begin n_err++; $display("FAIL inv_cont1_rsp: got %h required %h", p, e); end
    h2 = 8'($urandom_range(0, 255));
    hum_int = h2;
    send_cmd(8'h06);
    n_cmp++;
    if (tx_valid !== 1'b1) begin n_err++; $display("FAIL inv_latency: tx_valid=%b required 1", tx_valid); end
    rx_pair("inv_wrong_stop", 0, 0, p);
    e = model_rsp(8'h06, 1, 0, 1, hum_int, temp_int);
    n_cmp++;
    if (p !== e) begin n_err++; $display("FAIL inv_wrong_stop_rsp: got %h required %h", p, e); end
    rc = 8'($urandom_range(0, 255));
    if (rc == 8'h05) rc = 8'h06;
    send_cmd(rc);
    rx_pair("inv_rand_cont", 0, 0, p);
    e = model_rsp(rc, 1, 0, 1, hum_int, temp_int);
    n_cmp++;
    if (p !== e) begin n_err++; $display("FAIL inv_rand_cont_rsp: code %h got %h required %h", rc, p, e); end
    rx_pair("inv_cont2", 0, 0, p);
    e = model_rsp(8'h03, 0, 0, 1, h2, temp_int);
    n_cmp++;
    if (p !== e) begin n_err++; $display("FAIL inv_cont2_rsp: got %h required %h", p, e); end
    send_cmd(8'h05);
    rx_pair("inv_stop_hum", 0, 0, p);
    e = model_rsp(8'h05, 1, 0, 1, hum_int, temp_int);
    n_cmp++;
    if (p !== e) begin n_err++; $display("FAIL inv_stop_hum_rsp: got %h required %h", p, e); end
    foreach (p[i]) if (i < 2) begin
      rc = (i == 0) ? 8'hAA : 8'h05;
      send_cmd(rc);
      n_cmp++;
      if (tx_valid !== 1'b1) begin n_err++; $display("FAIL idle_inv_latency: tx_valid=%b required 1", tx_valid); end
      rx_pair("idle_inv", 0, 0, p);
      e = model_rsp(rc, 0, 0, 1, hum_int, temp_int);
      n_cmp++;
      if (p !== e) begin n_err++; $display("FAIL idle_inv_rsp: code %h got %h required %h", rc, p, e); end
    end
  endtask

  task automatic test_random;
    logic [15:0] p, e;
    logic [7:0] rc;
    int r0, m0;
    bit ok;
    for (int k = 0; k < 10; k++) begin
      rc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(5, 255));
      done_delay = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 30);
      hum_int  = 8'($urandom_range(0, 255));
      temp_int = 8'($urandom_range(0, 255));
      ok = (done_delay >= 0) && (done_delay <= TMO);
      r0 = rst_pulses; m0 = meas_cycles;
      send_cmd(rc);
      rx_pair("random", $urandom_range(0, 3), $urandom_range(0, 3), p);
      e = model_rsp(rc, 0, 0, ok, hum_int, temp_int);
      n_cmp++;
      if (p !== e) begin n_err++; $display("FAIL random_rsp: code %h got %h required %h", rc, p, e); end
      n_cmp++;
      if (rc <= 8'h04) begin
        if (rst_pulses - r0 !== 1 || meas_cycles - m0 !== model_meas(done_delay)) begin
          n_err++; $display("FAIL random_meas: pulses=%0d meas=%0d required 1/%0d",
                            rst_pulses - r0, meas_cycles - m0, model_meas(done_delay));
        end
      end else if (rst_pulses - r0 !== 0) begin
        n_err++; $display("FAIL random_no_meas: pulses=%0d required 0", rst_pulses - r0);
      end
    end
  endtask

  task automatic test_reset_midop;
    logic [15:0] p;
    logic [7:0] b;
    done_delay = -1;
    send_cmd(8'h02);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, sensor_enable, sensor_reset, tx_valid, tx_data} !== 19'd0) begin
      n_err++; $display("FAIL reset_measure: rdy=%b en=%h srst=%b txv=%b txd=%h required all 0",
                        cmd_ready, sensor_enable, sensor_reset, tx_valid, tx_data);
    end
    @(negedge clock); reset = 1'b1;
    done_delay = 4;
    hum_int = 8'($urandom_range(1, 255));
    send_cmd(8'h01);
    get_byte("reset_sv_code", 0, b);
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== hum_int) begin
      n_err++; $display("FAIL reset_sv_value: txv=%b txd=%h required 1/%h", tx_valid, tx_data, hum_int);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, sensor_enable, sensor_reset, tx_valid, tx_data} !== 19'd0) begin
      n_err++; $display("FAIL reset_send_value: rdy=%b en=%h srst=%b txv=%b txd=%h required all 0",
                        cmd_ready, sensor_enable, sensor_reset, tx_valid, tx_data);
    end
    @(negedge clock); reset = 1'b1;
    temp_int = 8'($urandom_range(0, 255));
    send_cmd(8'h02);
    rx_pair("after_reset", 0, 0, p);
    n_cmp++;
    if (p !== model_rsp(8'h02, 0, 0, 1, hum_int, temp_int)) begin
      n_err++; $display("FAIL after_reset_rsp: got %h required %h", p, model_rsp(8'h02, 0, 0, 1, hum_int, temp_int));
    end
  endtask

  initial begin
    test_reset;
    test_status;
    test_humidity;
    test_timeout;
    test_continuous;
    test_invalid;
    test_random;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
